// File: rtl/mag_compare_seq.sv
// mag_compare_seq: multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle, early exit.
module mag_compare_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             A_GT_B,
  output logic             B_GT_A
);
  localparam int N = WIDTH / CHUNK;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  if (CHUNK <= 0 || WIDTH <= 0 || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("mag_compare_seq: WIDTH must be a positive multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [JW-1:0]    j_q;
  logic [CHUNK-1:0] ca, cb;
  logic             busy_q, done_q, eq_q, gt_q, lt_q;
  // operands shift left each equal cycle, so the active chunk is always on top
  assign ca = a_q[WIDTH-1 -: CHUNK];
  assign cb = b_q[WIDTH-1 -: CHUNK];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == SCAN) begin
        if (ca != cb || j_q == J_LAST) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          eq_q    <= ca == cb;
          gt_q    <= ca > cb;
          lt_q    <= ca < cb;
        end else begin
          j_q <= j_q + 1'b1;
          a_q <= a_q << CHUNK;
          b_q <= b_q << CHUNK;
        end
      end else if (start) begin
        // flipping the sign bit maps two's-complement order onto unsigned order
        state_q <= SCAN;
        a_q     <= signed_mode ? A ^ MSB : A;
        b_q     <= signed_mode ? B ^ MSB : B;
        j_q     <= '0;
        busy_q  <= 1'b1;
        eq_q    <= 1'b0;
        gt_q    <= 1'b0;
        lt_q    <= 1'b0;
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign EQ     = eq_q;
  assign A_GT_B = gt_q;
  assign B_GT_A = lt_q;
endmodule

// File: tb/tb_mag_compare_seq.sv
// tb_mag_compare_seq: randomized and directed checks of mag_compare_seq against an arithmetic model.
module tb_mag_compare_seq;
  logic clk = 0, rst = 1, start = 0, signed_mode = 0;
  logic [15:0] A = 0, B = 0;
  logic busy, done, EQ, A_GT_B, B_GT_A;
  int errors = 0, checks = 0;

  mag_compare_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .A(A), .B(B),
    .busy(busy), .done(done), .EQ(EQ), .A_GT_B(A_GT_B), .B_GT_A(B_GT_A)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (busy && done) begin
      errors++;
      $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1", busy, done);
    end
  end

  // result {EQ,A_GT_B,B_GT_A} from integer comparison; latency from first differing bit
  function automatic void model(input logic [15:0] a, b, input logic s, output logic [2:0] r, output int lat);
    int ia, ib;
    logic [15:0] x;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    r = (ia == ib) ? 3'b100 : (ia > ib) ? 3'b010 : 3'b001;
    x = a ^ b;
    lat = 4;
    for (int i = 0; i < 16; i++) if (x[i]) lat = (15 - i) / 4 + 1;
  endfunction

  // issue one start and count edges until done; lat=-1 on timeout
  task automatic run(input logic [15:0] a, b, input logic s, output int lat);
    @(negedge clk);
    A = a; B = b; signed_mode = s; start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    int lat;
    checks++;
    if ({busy, done, EQ, A_GT_B, B_GT_A} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got %b required 00000", {busy, done, EQ, A_GT_B, B_GT_A});
    end
    @(negedge clk); rst = 0;
    @(negedge clk);
    A = 16'h0001; B = 16'h0001; signed_mode = 0; start = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #2;
    rst = 1;
    #1;
    checks++;
    if ({busy, done, EQ, A_GT_B, B_GT_A} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_midscan: got %b required 00000", {busy, done, EQ, A_GT_B, B_GT_A});
    end
    @(negedge clk); rst = 0;
    run(16'h0001, 16'h0000, 0, lat);
    checks++;
    if (lat !== 4 || {EQ, A_GT_B, B_GT_A} !== 3'b010) begin
      errors++;
      $display("FAIL after_reset: lat=%0d res=%b required lat=4 res=010", lat, {EQ, A_GT_B, B_GT_A});
    end
  endtask

  task automatic test_directed;
    logic [15:0] ta [6] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF, 16'h12A4};
    logic [15:0] tb [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h12B4};
    logic        ts [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  tr [6] = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001};
    int          tl [6] = '{4, 4, 1, 1, 1, 3};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run(ta[i], tb[i], ts[i], lat);
      checks++;
      if (lat !== tl[i] || {EQ, A_GT_B, B_GT_A} !== tr[i]) begin
        errors++;
        $display("FAIL directed_%0d: lat=%0d res=%b required lat=%0d res=%b", i, lat, {EQ, A_GT_B, B_GT_A}, tl[i], tr[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done, EQ, A_GT_B, B_GT_A} !== 4'b0001) begin
      errors++;
      $display("FAIL result_hold: got %b required 0001", {done, EQ, A_GT_B, B_GT_A});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    A = 16'h0000; B = 16'h0001; signed_mode = 0; start = 1;
    @(posedge clk); #1; start = 0;
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0000; start = 1;
    @(posedge clk); #1; start = 0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || !done || {EQ, A_GT_B, B_GT_A} !== 3'b001) begin
      errors++;
      $display("FAIL busy_start_ignored: lat=%0d done=%b res=%b required lat=4 done=1 res=001", lat, done, {EQ, A_GT_B, B_GT_A});
    end
    A = 16'h5000; B = 16'h4000; start = 1;
    @(posedge clk); #1; start = 0;
    checks++;
    if ({busy, done, EQ, A_GT_B, B_GT_A} !== 5'b10000) begin
      errors++;
      $display("FAIL b2b_accept: got %b required 10000", {busy, done, EQ, A_GT_B, B_GT_A});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, EQ, A_GT_B, B_GT_A} !== 5'b01010) begin
      errors++;
      $display("FAIL b2b_result: got %b required 01010", {busy, done, EQ, A_GT_B, B_GT_A});
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    logic s;
    logic [2:0] r;
    int lat, el;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 2))
        0: b = 16'($urandom);
        1: b = a ^ (16'h1 << $urandom_range(0, 15));
        default: b = a;
      endcase
      s = 1'($urandom);
      model(a, b, s, r, el);
      run(a, b, s, lat);
      checks++;
      if (lat !== el || {EQ, A_GT_B, B_GT_A} !== r) begin
        errors++;
        $display("FAIL random a=%h b=%h s=%b: lat=%0d res=%b required lat=%0d res=%b", a, b, s, lat, {EQ, A_GT_B, B_GT_A}, el, r);
      end
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_directed;
    test_back_to_back;
    test_random;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mag_compare_seq.md
# mag_compare_seq

Parameterised, multi-cycle magnitude comparator, the next generation of the ALU's 4-bit combinational comparator. It latches two WIDTH-bit operands on a start strobe and scans them MSB-first, CHUNK bits per cycle, with unsigned or two's-complement interpretation selected per operation. It terminates early on the first differing chunk and reports EQ / A_GT_B / B_GT_A with a one-cycle done pulse. It sits behind the ALU control FSM, where wide compares must not lengthen the critical path.

## Interface
- WIDTH, default 16, operand width in bits; must be a positive multiple of CHUNK.
- CHUNK, default 4, bits compared per cycle. WIDTH % CHUNK != 0 is an elaboration error.
- N (derived, localparam) = WIDTH/CHUNK, the number of chunks.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a compare; accepted only when busy=0.
- signed_mode  input  1  1 = two's-complement, 0 = unsigned; latched with the operands.
- A  input  WIDTH  operand A; latched on accepted start.
- B  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when the result is valid.
- EQ  output  1  A == B.
- A_GT_B  output  1  A > B.
- B_GT_A  output  1  B > A.

## Operation
- States:
  - IDLE: the reset state.
  - SCAN: compares one chunk per cycle. Chunk index j runs 0..N-1, where chunk 0 = bits [WIDTH-1 : WIDTH-CHUNK].
  - DONE: lasts one cycle.
- Accepted start (busy=0, in IDLE or DONE):
  - Latch A, B and signed_mode.
  - Clear EQ, A_GT_B and B_GT_A to 0.
  - Set j=0 and enter SCAN.
- Signed handling: when signed_mode=1, invert bit WIDTH-1 of both latched operands. After that, an unsigned compare is correct.
- SCAN, each cycle, compares chunk j of A with chunk j of B as unsigned:
  - A chunk > B chunk: set A_GT_B=1 and go to DONE.
  - A chunk < B chunk: set B_GT_A=1 and go to DONE.
  - Equal and j == N-1: set EQ=1 and go to DONE.
  - Equal otherwise: j <= j+1 and stay in SCAN.
- DONE:
  - done=1 for this one cycle.
  - Next state is IDLE, or SCAN if start is asserted in this cycle (back-to-back).
- Results are held from DONE until the next accepted start or reset. Exactly one result bit is high after any completed compare.
- start while busy=1 is ignored. It is not queued and has no effect on the latched operands or the state.
- Changes on A, B or signed_mode during SCAN have no effect.
- Counter j is ceil(log2(N)) bits wide, minimum 1. It never wraps, because SCAN always exits at j = N-1.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-SCAN):
  - state = IDLE.
  - busy, done, EQ, A_GT_B and B_GT_A all = 0.
  - Latched operands and j are don't-care.
- Let start be sampled at rising edge E0. Then:
  - busy=1 from after E0.
  - If the first differing chunk is j, done=1 and the result is valid after edge E0+j+1, with busy=0 in the same cycle.
  - If all chunks are equal, latency is N cycles.
- Latency range: minimum 1 cycle, maximum N cycles (4 at the defaults).
- done is high for exactly one cycle.
- Throughput: a new start sampled in the done cycle is accepted, giving zero idle cycles between operations.
- busy and done are never high simultaneously.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Reset mid-operation: assert rst during SCAN of A=0x0001, B=0x0001. Required: busy, done and all results go to 0 without a clock edge. After release, start with A=0x0001, B=0x0000 gives A_GT_B after 4 cycles.
- Equality, worst-case latency: A=0x1234, B=0x1234, unsigned. Required: done 4 cycles after start, EQ=1, others 0. With signed_mode=1 and A=B=0xFFFF: EQ=1 after 4 cycles.
- Sign mode on MSB: A=0x8000, B=0x7FFF.
  - Unsigned: A_GT_B=1 after 1 cycle.
  - Signed: B_GT_A=1 after 1 cycle.
  - Signed A=0xFFFF (-1) vs B=0x0000: B_GT_A=1 after 1 cycle.
- Early termination: A=0x12A4, B=0x12B4, unsigned. Required: done exactly 3 cycles after start, B_GT_A=1. Results stay held until the next start.
- Handshake:
  - Start A=0x0000, B=0x0001. One cycle later, pulse start with A=0xFFFF, B=0x0000. Required: second start ignored; B_GT_A=1 after 4 cycles.
  - Then, in the done cycle, start A=0x5000, B=0x4000. Required: accepted back-to-back, results clear, A_GT_B=1 one cycle later.
